irq_pending_latch: RTL and testbench
====================================

# irq_pending_latch

Eight-channel interrupt request latch that sits directly upstream of the 8:3 priority encoder. It detects rising edges on raw request lines and holds each as a pending bit until it is acknowledged. It presents the masked pending vector as the encoder's 8-bit data input and takes back the encoded channel number as the acknowledge index. It also flags lost (overrun) edges and bad acknowledges.

## Interface
Parameters: none; width fixed at 8 channels, 3-bit index.

Ports:
- clk  input  1  rising-edge clock, single clock domain
- rst  input  1  asynchronous, active-high reset
- en  input  1  capture enable; 0 = new edges ignored
- req  input  8  raw request lines; bit i is channel i
- mask  input  8  1 = channel masked from pend/irq (still latched)
- ack  input  1  one-cycle acknowledge strobe
- ack_id  input  3  channel being acknowledged (encoder dout)
- pend  output  8  pend_raw & ~mask, combinational from registers (encoder din)
- irq  output  1  |pend, combinational
- ovf  output  8  sticky overrun flag per channel, registered
- ack_err  output  1  registered one-cycle pulse: ack to a non-pending channel

## Operation
- Internal registers: pend_raw[7:0], req_q[7:0] (previous sampled req), ovf[7:0], ack_err.
- Edge detect: rise = req_s & ~req_q, where req_s is req (or its synchronized copy, see Configuration). req_q <= req_s every cycle regardless of en.
- Capture gate: set = en ? rise : 8'h00.
- Clear: clr = ack ? (8'h01 << ack_id) : 8'h00.
- Update: pend_raw <= (pend_raw & ~clr) | set. Set and clear of the same bit in one cycle: set wins; the bit stays pending.
- Overrun: ovf[i] <= 1 when set[i]=1, pend_raw[i]=1 and clr[i]=0. ovf[i] is cleared by an ack of channel i. Clear and new overrun in the same cycle: clear wins, because no edge is lost (the set re-pends the bit).
- ack_err <= ack & ~pend_raw[ack_id]. It is evaluated on unmasked pend_raw, so acking a masked but pending channel is legal.
- Masking is output-only: masked channels keep latching, and unmasking immediately exposes them on pend/irq.
- en=0: pending bits and ovf are held, ack still clears, edges occurring while en=0 are lost (not deferred).

## Timing
- Reset (async assert, sync-safe deassert by system): pend_raw=0, ovf=0, ack_err=0, so pend=0 and irq=0. req_q=8'hFF: a line already high at reset release is not captured and must go low then high.
- Capture latency: req[i] first sampled high at edge k → pend[i] and irq high after edge k (1 cycle). With sync: after edge k+2.
- Clear latency: ack sampled at edge k → bit drops after edge k, ack_err valid for the cycle following edge k.
- Mask change affects pend/irq combinationally in the same cycle.
- Reset asserted mid-operation clears all state immediately. Requests held high across reset are ignored per the req_q rule.
- ack is sampled every cycle it is high. Holding ack for 2 cycles on the same id gives ack_err on the second if no new edge arrived.

## Configuration
- IRQ_SYNC_EN defined: req passes through a 2-flop synchronizer (reset to 8'hFF) before edge detection, so req_s = req delayed 2 cycles and capture latency is 3 cycles. Use for asynchronous request sources.
- Not defined: req_s = req directly, capture latency is 1 cycle, and req must be synchronous to clk.

## Test plan
- Reset with req=8'h01 held high, release, keep high 5 cycles → pend=8'h00, irq=0. Drop then raise req[0] → pend=8'h01 one cycle after the rising sample.
- Rising edges on channels 2 and 6 same cycle, mask=8'h40 → pend=8'h04, irq=1. Clear mask → pend=8'h44.
- pend=8'h44, ack=1 ack_id=6 → pend=8'h04, ack_err=0. Next cycle ack_id=6 again → ack_err=1 for one cycle, pend unchanged.
- Channel 3 pending, second rising edge on req[3] without ack → ovf=8'h08. ack_id=3 → pend[3]=0, ovf=8'h00.
- ack_id=5 in the same cycle as a new req[5] edge while pending → pend[5] stays 1, ovf[5]=0, ack_err=0.
- en=0, pulse req=8'hFF, then en=1 → pend=8'h00. With IRQ_SYNC_EN, an edge on req[1] reaches pend after 3 cycles.

Source files
------------

// File: rtl/irq_pending_latch.sv
// Eight-channel rising-edge interrupt latch feeding an 8:3 priority encoder.
// Define IRQ_SYNC_EN to add a 2-flop synchronizer on req for asynchronous sources.
module irq_pending_latch (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] req,
    input  logic [7:0] mask,
    input  logic       ack,
    input  logic [2:0] ack_id,
    output logic [7:0] pend,
    output logic       irq,
    output logic [7:0] ovf,
    output logic       ack_err
);

    logic [7:0] req_s;
    logic [7:0] req_q;
    logic [7:0] pend_raw_q, pend_raw_d;
    logic [7:0] ovf_q, ovf_d;
    logic       ack_err_q, ack_err_d;
    logic [7:0] rise, set, clr;

`ifdef IRQ_SYNC_EN
    logic [7:0] sync1_q, sync2_q;

    // Reset high so lines already asserted at release do not look like edges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 8'hFF;
            sync2_q <= 8'hFF;
        end else begin
            sync1_q <= req;
            sync2_q <= sync1_q;
        end
    end

    assign req_s = sync2_q;
`else
    assign req_s = req;
`endif

    always_comb begin
        rise       = req_s & ~req_q;
        set        = en ? rise : 8'h00;
        clr        = ack ? (8'h01 << ack_id) : 8'h00;
        pend_raw_d = (pend_raw_q & ~clr) | set;
        // An ack in the same cycle as a repeat edge loses nothing, so it also clears ovf.
        ovf_d      = (ovf_q & ~clr) | (set & pend_raw_q & ~clr);
        ack_err_d  = ack & ~pend_raw_q[ack_id];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q      <= 8'hFF;
            pend_raw_q <= 8'h00;
            ovf_q      <= 8'h00;
            ack_err_q  <= 1'b0;
        end else begin
            req_q      <= req_s;
            pend_raw_q <= pend_raw_d;
            ovf_q      <= ovf_d;
            ack_err_q  <= ack_err_d;
        end
    end

    assign pend    = pend_raw_q & ~mask;
    assign irq     = |pend;
    assign ovf     = ovf_q;
    assign ack_err = ack_err_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed self-checking bench for irq_pending_latch (default build, no synchronizer).
`timescale 1ns/1ps
module tb_irq_pending_latch;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic [2:0] ack_id;
    logic [7:0] pend;
    logic       irq;
    logic [7:0] ovf;
    logic       ack_err;

    int chk_cnt = 0;
    int err_cnt = 0;

    irq_pending_latch dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .req    (req),
        .mask   (mask),
        .ack    (ack),
        .ack_id (ack_id),
        .pend   (pend),
        .irq    (irq),
        .ovf    (ovf),
        .ack_err(ack_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock edge, then settle 1ns so inputs change and checks happen away from the edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; req = 8'h01; mask = 8'h00; ack = 1'b0; ack_id = 3'd0;
        tick(3);
        check("rst_pend", pend, 8'h00);
        check("rst_irq", {7'b0, irq}, 8'h00);
        check("rst_ovf", ovf, 8'h00);
        check("rst_ackerr", {7'b0, ack_err}, 8'h00);

        rst = 1'b0;
        tick(5);
        check("held_high_pend", pend, 8'h00);
        check("held_high_irq", {7'b0, irq}, 8'h00);
        req = 8'h00; tick();
        req = 8'h01; tick();
        check("ch0_capture", pend, 8'h01);
        check("ch0_irq", {7'b0, irq}, 8'h01);
        ack = 1'b1; ack_id = 3'd0; tick();
        ack = 1'b0;
        check("ch0_ack_pend", pend, 8'h00);
        check("ch0_ack_err", {7'b0, ack_err}, 8'h00);

        // Channels 2 and 6 together, 6 masked
        req = 8'h45; mask = 8'h40; tick();
        check("mask_pend", pend, 8'h04);
        check("mask_irq", {7'b0, irq}, 8'h01);
        mask = 8'h00; #1;
        check("unmask_pend", pend, 8'h44);

        ack = 1'b1; ack_id = 3'd6; tick();
        check("ack6_pend", pend, 8'h04);
        check("ack6_err", {7'b0, ack_err}, 8'h00);
        tick();
        check("ack6_again_err", {7'b0, ack_err}, 8'h01);
        check("ack6_again_pend", pend, 8'h04);
        ack = 1'b0; tick();
        check("ackerr_pulse_end", {7'b0, ack_err}, 8'h00);

        // Overrun on channel 3
        req = 8'h4D; tick();
        check("ch3_pend", pend, 8'h0C);
        check("ch3_no_ovf", ovf, 8'h00);
        req = 8'h45; tick();
        req = 8'h4D; tick();
        check("ch3_ovf", ovf, 8'h08);
        check("ch3_ovf_pend", pend, 8'h0C);
        ack = 1'b1; ack_id = 3'd3; req = 8'h45; tick();
        ack = 1'b0;
        check("ch3_ack_pend", pend, 8'h04);
        check("ch3_ack_ovf", ovf, 8'h00);

        // Ack and new edge on channel 5 in the same cycle
        req = 8'h65; tick();
        check("ch5_pend", pend, 8'h24);
        req = 8'h45; tick();
        req = 8'h65; ack = 1'b1; ack_id = 3'd5; tick();
        ack = 1'b0; req = 8'h45;
        check("ch5_setwins_pend", pend, 8'h24);
        check("ch5_setwins_ovf", ovf, 8'h00);
        check("ch5_setwins_err", {7'b0, ack_err}, 8'h00);

        // en=0: ack still clears, edges are lost
        en = 1'b0;
        ack = 1'b1; ack_id = 3'd2; tick();
        check("en0_ack2", pend, 8'h20);
        ack_id = 3'd5; tick();
        ack = 1'b0;
        check("en0_ack5", pend, 8'h00);
        req = 8'hFF; tick();
        req = 8'h00; tick();
        en = 1'b1; tick();
        check("en0_lost_pend", pend, 8'h00);
        check("en0_lost_irq", {7'b0, irq}, 8'h00);

        // Masked channel still latches and may be acked without error
        mask = 8'h02; req = 8'h02; tick();
        check("masked_pend", pend, 8'h00);
        check("masked_irq", {7'b0, irq}, 8'h00);
        mask = 8'h00; #1;
        check("unmasked_ch1", pend, 8'h02);
        mask = 8'h02; ack = 1'b1; ack_id = 3'd1; tick();
        ack = 1'b0; mask = 8'h00; #1;
        check("masked_ack_err", {7'b0, ack_err}, 8'h00);
        check("masked_ack_pend", pend, 8'h00);

        // Mid-operation reset with pending and overrun state
        req = 8'h00; tick();
        req = 8'h80; tick();
        req = 8'h00; tick();
        req = 8'h80; tick();
        check("pre_rst_pend", pend, 8'h80);
        check("pre_rst_ovf", ovf, 8'h80);
        #2 rst = 1'b1; #1;
        check("async_rst_pend", pend, 8'h00);
        check("async_rst_ovf", ovf, 8'h00);
        tick(); rst = 1'b0; tick(2);
        check("post_rst_held", pend, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", chk_cnt, err_cnt);
        $finish;
    end

endmodule
